// File: rtl/fma_vector_checker.sv
// fma_vector_checker
//   Self-check engine for an fmaN datapath. It streams packed vectors
//   {x,y,z,ctrl[7:0],rexp,fexp} from a synchronous-read vector RAM into a DUT
//   of fixed latency LAT. It compares the DUT result, and the flags when
//   requested, then counts vectors and errors and captures the first mismatch.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  one-cycle pulse that begins a run at address 0
//   check_flags            1 = a flag mismatch also counts as an error
//   stop_on_err            1 = stop reading after the first error
//   mem_en, mem_addr       RAM read request
//   mem_rdata, mem_present RAM data, one cycle after mem_en; present=0 marks end of list
//   x, y, z, roundmode,
//   mul, add, negp, negz   registered DUT operands
//   dut_result, dut_flags  DUT response, LAT cycles after the operands
//   busy, done, pass       run status
//   vec_count, err_count   vectors compared / mismatches (saturating)
//   first_idx, first_got,
//   first_exp              capture of the first mismatch
module fma_vector_checker #(
  parameter int W   = 16,
  parameter int FW  = 4,
  parameter int LAT = 0,
  parameter int AW  = 14,
  parameter int CW  = 32,
  localparam int VW = 4*W + 8 + FW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          check_flags,
  input  logic          stop_on_err,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [VW-1:0] mem_rdata,
  input  logic          mem_present,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  output logic [W-1:0]  z,
  output logic [1:0]    roundmode,
  output logic          mul,
  output logic          add,
  output logic          negp,
  output logic          negz,
  input  logic [W-1:0]  dut_result,
  input  logic [FW-1:0] dut_flags,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] vec_count,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] first_idx,
  output logic [W+FW-1:0] first_got,
  output logic [W+FW-1:0] first_exp
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [AW-1:0] addr_q;
  logic          addr_done, rd_vld, rd_last;
  logic          chk_q, stop_q;
  logic [CW-1:0] idx_q;
  logic          load_now, end_now, stop_hit, start_ok, up_pend;
  logic          err_now, cmp_v;

  logic [W-1:0]  rd_x, rd_y, rd_z, rd_rexp;
  logic [7:0]    rd_ctrl;
  logic [FW-1:0] rd_fexp;
  logic [1:0]    unused_ctrl;

  // Stage 0 is the issue register; stage LAT lines up with the DUT response.
  logic [LAT:0]  stv;
  logic [W-1:0]  st_rexp [0:LAT];
  logic [FW-1:0] st_fexp [0:LAT];
  logic [CW-1:0] st_idx  [0:LAT];

  assign rd_fexp     = mem_rdata[FW-1:0];
  assign rd_rexp     = mem_rdata[FW +: W];
  assign rd_ctrl     = mem_rdata[FW+W +: 8];
  assign rd_z        = mem_rdata[FW+W+8 +: W];
  assign rd_y        = mem_rdata[FW+2*W+8 +: W];
  assign rd_x        = mem_rdata[FW+3*W+8 +: W];
  assign unused_ctrl = rd_ctrl[7:6];

  assign mem_addr = addr_q;
  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign busy     = (state == S_FETCH) || (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign pass     = done && (err_count == '0);

  assign cmp_v   = stv[LAT];
  assign err_now = cmp_v && ((dut_result !== st_rexp[LAT]) ||
                             (chk_q && (dut_flags !== st_fexp[LAT])));

  // Vectors still upstream of the compare stage; once none remain, the
  // vector being compared this cycle is the last one of the run.
  always_comb begin
    up_pend = 1'b0;
    for (int i = 0; i < LAT; i++) up_pend = up_pend | stv[i];
  end

  // A read issued in the cycle that ends the run is simply never loaded.
  always_comb begin
    state_nx = state;
    mem_en   = 1'b0;
    load_now = 1'b0;
    end_now  = 1'b0;
    stop_hit = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_FETCH;
      S_FETCH: begin
        mem_en   = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        mem_en   = !addr_done;
        stop_hit = stop_q && err_now;
        end_now  = stop_hit || (rd_vld && (!mem_present || rd_last));
        load_now = rd_vld && mem_present && !stop_hit;
        if (end_now) state_nx = (up_pend || load_now) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: if (!up_pend) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Read sequencing. After the top address is read no further reads occur,
  // and the arrival of that data ends the list.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      addr_done <= 1'b0;
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
      chk_q     <= 1'b0;
      stop_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      state   <= state_nx;
      rd_vld  <= mem_en && !end_now;
      rd_last <= mem_en && !end_now && (addr_q == {AW{1'b1}});
      if (start_ok) begin
        addr_q    <= '0;
        addr_done <= 1'b0;
        chk_q     <= check_flags;
        stop_q    <= stop_on_err;
        idx_q     <= '0;
      end else begin
        if (mem_en) begin
          if (addr_q == {AW{1'b1}}) addr_done <= 1'b1;
          else                      addr_q    <= addr_q + AW'(1);
        end
        if (load_now) idx_q <= idx_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      roundmode <= '0;
      mul       <= 1'b0;
      add       <= 1'b0;
      negp      <= 1'b0;
      negz      <= 1'b0;
    end else if (load_now) begin
      x         <= rd_x;
      y         <= rd_y;
      z         <= rd_z;
      roundmode <= rd_ctrl[5:4];
      mul       <= rd_ctrl[3];
      add       <= rd_ctrl[2];
      negp      <= rd_ctrl[1];
      negz      <= rd_ctrl[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stv <= '0;
      for (int i = 0; i <= LAT; i++) begin
        st_rexp[i] <= '0;
        st_fexp[i] <= '0;
        st_idx[i]  <= '0;
      end
    end else begin
      stv[0] <= load_now;
      if (load_now) begin
        st_rexp[0] <= rd_rexp;
        st_fexp[0] <= rd_fexp;
        st_idx[0]  <= idx_q;
      end
      for (int i = 1; i <= LAT; i++) begin
        stv[i]     <= stv[i-1];
        st_rexp[i] <= st_rexp[i-1];
        st_fexp[i] <= st_fexp[i-1];
        st_idx[i]  <= st_idx[i-1];
      end
    end
  end

  // err_count only leaves zero on the first error, so zero doubles as the
  // "nothing captured yet" marker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_count <= '0;
      err_count <= '0;
      first_idx <= '0;
      first_got <= '0;
      first_exp <= '0;
    end else if (start_ok) begin
      vec_count <= '0;
      err_count <= '0;
      first_idx <= '0;
      first_got <= '0;
      first_exp <= '0;
    end else if (cmp_v) begin
      vec_count <= vec_count + CW'(1);
      if (err_now) begin
        if (err_count != '1) err_count <= err_count + CW'(1);
        if (err_count == '0) begin
          first_idx <= st_idx[LAT];
          first_got <= {dut_result, dut_flags};
          first_exp <= {st_rexp[LAT], st_fexp[LAT]};
        end
      end
    end
  end

endmodule

// File: tb/tb_fma_vector_checker.sv
// tb_fma_vector_checker
//   Bench for fma_vector_checker with LAT=3 and a 128-entry vector RAM. A
//   stand-in "fma" (an arbitrary fixed function of the operands) answers with
//   three cycles of latency. Expected results are derived from the vector
//   list alone.
module tb_fma_vector_checker;

  localparam int W     = 16;
  localparam int FW    = 4;
  localparam int LAT   = 3;
  localparam int AW    = 7;
  localparam int CW    = 32;
  localparam int VW    = 4*W + 8 + FW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          check_flags = 1'b0;
  logic          stop_on_err = 1'b0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [VW-1:0] mem_rdata = '0;
  logic          mem_present = 1'b0;
  logic [W-1:0]  x, y, z;
  logic [1:0]    roundmode;
  logic          mul, add, negp, negz;
  logic [W-1:0]  dut_result;
  logic [FW-1:0] dut_flags;
  logic          busy, done, pass;
  logic [CW-1:0] vec_count, err_count, first_idx;
  logic [W+FW-1:0] first_got, first_exp;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  vx [DEPTH];
  logic [W-1:0]  vy [DEPTH];
  logic [W-1:0]  vz [DEPTH];
  logic [W-1:0]  vr [DEPTH];
  logic [7:0]    vc [DEPTH];
  logic [FW-1:0] vf [DEPTH];
  bit            vp [DEPTH];

  int              exp_n, exp_vec, exp_err;
  logic [CW-1:0]   exp_fidx;
  logic [W+FW-1:0] exp_got, exp_exp;

  fma_vector_checker #(.W(W), .FW(FW), .LAT(LAT), .AW(AW), .CW(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .check_flags(check_flags),
    .stop_on_err(stop_on_err), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_present(mem_present), .x(x), .y(y), .z(z),
    .roundmode(roundmode), .mul(mul), .add(add), .negp(negp), .negz(negz),
    .dut_result(dut_result), .dut_flags(dut_flags), .busy(busy), .done(done),
    .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .first_idx(first_idx), .first_got(first_got), .first_exp(first_exp)
  );

  always #5 clk = ~clk;

  function automatic logic [W+FW-1:0] fake_fma(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [W-1:0] c, input logic [5:0] k);
    logic [W-1:0] r;
    r = (a ^ {b[7:0], b[15:8]}) + c + {10'd0, k};
    return {r, r[3:0] ^ r[15:12]};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata   <= {vx[mem_addr], vy[mem_addr], vz[mem_addr], vc[mem_addr], vr[mem_addr], vf[mem_addr]};
      mem_present <= vp[mem_addr];
    end
  end

  logic [W+FW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fake_fma(x, y, z, {roundmode, mul, add, negp, negz});
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {dut_result, dut_flags} = pipe[LAT-1];

  task automatic fill_list(input int n);
    for (int i = 0; i < DEPTH; i++) begin
      vx[i] = W'($urandom);
      vy[i] = W'($urandom);
      vz[i] = W'($urandom);
      vc[i] = 8'($urandom);
      {vr[i], vf[i]} = fake_fma(vx[i], vy[i], vz[i], vc[i][5:0]);
      vp[i] = (i < n);
    end
  endtask

  // Walk the list in order: stop at the first absent entry or the end of
  // RAM. With stop_on_err, the LAT vectors following the first error are
  // already in flight and are still compared.
  task automatic model(input bit chk, input bit stp);
    int limit;
    logic [W+FW-1:0] g;
    bit e;
    exp_n = 0;
    while (exp_n < DEPTH && vp[exp_n]) exp_n++;
    exp_vec = 0; exp_err = 0; exp_fidx = '0; exp_got = '0; exp_exp = '0;
    limit = exp_n;
    for (int i = 0; i < exp_n; i++) begin
      if (i >= limit) break;
      g = fake_fma(vx[i], vy[i], vz[i], vc[i][5:0]);
      e = (g[W+FW-1:FW] != vr[i]) || (chk && (g[FW-1:0] != vf[i]));
      exp_vec++;
      if (e) begin
        if (exp_err == 0) begin
          exp_fidx = CW'(i);
          exp_got  = g;
          exp_exp  = {vr[i], vf[i]};
          if (stp) limit = (i + 1 + LAT < exp_n) ? i + 1 + LAT : exp_n;
        end
        exp_err++;
      end
    end
  endtask

  task automatic run_checker(input bit chk, input bit stp, output int cyc, output bit to);
    @(negedge clk);
    check_flags = chk;
    stop_on_err = stp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    to = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0)    begin bad++; $display("[TB] FAIL reset_busy got=%0h want=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("[TB] FAIL reset_done got=%0h want=0", done); end
    total++; if (pass !== 1'b0)    begin bad++; $display("[TB] FAIL reset_pass got=%0h want=0", pass); end
    total++; if (mem_en !== 1'b0)  begin bad++; $display("[TB] FAIL reset_mem_en got=%0h want=0", mem_en); end
    total++; if (vec_count !== '0) begin bad++; $display("[TB] FAIL reset_vec got=%0h want=0", vec_count); end
    total++; if (x !== '0)         begin bad++; $display("[TB] FAIL reset_x got=%0h want=0", x); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (done !== 1'b0)    begin bad++; $display("[TB] FAIL idle_done got=%0h want=0", done); end
  endtask

  task automatic test_single;
    int cyc; bit to;
    fill_list(1);
    model(1'b1, 1'b0);
    run_checker(1'b1, 1'b0, cyc, to);
    total++; if (to !== 1'b0)             begin bad++; $display("[TB] FAIL single_timeout got=%0d want=0", to); end
    total++; if (cyc !== exp_n + LAT + 2) begin bad++; $display("[TB] FAIL single_latency got=%0d want=%0d", cyc, exp_n + LAT + 2); end
    total++; if (vec_count !== CW'(exp_vec)) begin bad++; $display("[TB] FAIL single_vec got=%0d want=%0d", vec_count, exp_vec); end
    total++; if (pass !== 1'b1)           begin bad++; $display("[TB] FAIL single_pass got=%0h want=1", pass); end
  endtask

  task automatic test_stream;
    int cyc; bit to;
    fill_list(100);
    model(1'b1, 1'b0);
    run_checker(1'b1, 1'b0, cyc, to);
    total++; if (to !== 1'b0)             begin bad++; $display("[TB] FAIL stream_timeout got=%0d want=0", to); end
    total++; if (cyc !== exp_n + LAT + 2) begin bad++; $display("[TB] FAIL stream_latency got=%0d want=%0d", cyc, exp_n + LAT + 2); end
    total++; if (vec_count !== CW'(exp_vec)) begin bad++; $display("[TB] FAIL stream_vec got=%0d want=%0d", vec_count, exp_vec); end
    total++; if (err_count !== CW'(exp_err)) begin bad++; $display("[TB] FAIL stream_err got=%0d want=%0d", err_count, exp_err); end
    total++; if (pass !== 1'b1)           begin bad++; $display("[TB] FAIL stream_pass got=%0h want=1", pass); end
    total++; if ({x, z} !== {vx[99], vz[99]}) begin bad++; $display("[TB] FAIL stream_hold got=%0h want=%0h", {x, z}, {vx[99], vz[99]}); end
    total++; if ({roundmode, mul, add, negp, negz} !== vc[99][5:0])
      begin bad++; $display("[TB] FAIL stream_ctrl got=%0h want=%0h", {roundmode, mul, add, negp, negz}, vc[99][5:0]); end
  endtask

  task automatic test_mismatch;
    int cyc; bit to;
    fill_list(40);
    vr[5]  = vr[5] ^ 16'h0200;
    vr[22] = vr[22] ^ 16'h0001;
    model(1'b0, 1'b0);
    run_checker(1'b0, 1'b0, cyc, to);
    total++; if (to !== 1'b0)                 begin bad++; $display("[TB] FAIL mism_timeout got=%0d want=0", to); end
    total++; if (vec_count !== CW'(exp_vec))  begin bad++; $display("[TB] FAIL mism_vec got=%0d want=%0d", vec_count, exp_vec); end
    total++; if (err_count !== CW'(exp_err))  begin bad++; $display("[TB] FAIL mism_err got=%0d want=%0d", err_count, exp_err); end
    total++; if (first_idx !== exp_fidx)      begin bad++; $display("[TB] FAIL mism_idx got=%0d want=%0d", first_idx, exp_fidx); end
    total++; if (first_got !== exp_got)       begin bad++; $display("[TB] FAIL mism_got got=%0h want=%0h", first_got, exp_got); end
    total++; if (first_exp !== exp_exp)       begin bad++; $display("[TB] FAIL mism_exp got=%0h want=%0h", first_exp, exp_exp); end
    total++; if (pass !== 1'b0)               begin bad++; $display("[TB] FAIL mism_pass got=%0h want=0", pass); end
  endtask

  task automatic test_flags;
    int cyc; bit to;
    fill_list(30);
    vf[7] = vf[7] ^ 4'h1;
    model(1'b0, 1'b0);
    run_checker(1'b0, 1'b0, cyc, to);
    total++; if (to !== 1'b0)                begin bad++; $display("[TB] FAIL flags_off_timeout got=%0d want=0", to); end
    total++; if (err_count !== CW'(exp_err)) begin bad++; $display("[TB] FAIL flags_off_err got=%0d want=%0d", err_count, exp_err); end
    total++; if (pass !== 1'b1)              begin bad++; $display("[TB] FAIL flags_off_pass got=%0h want=1", pass); end
    model(1'b1, 1'b0);
    run_checker(1'b1, 1'b0, cyc, to);
    total++; if (to !== 1'b0)                begin bad++; $display("[TB] FAIL flags_on_timeout got=%0d want=0", to); end
    total++; if (err_count !== CW'(exp_err)) begin bad++; $display("[TB] FAIL flags_on_err got=%0d want=%0d", err_count, exp_err); end
    total++; if (first_idx !== exp_fidx)     begin bad++; $display("[TB] FAIL flags_on_idx got=%0d want=%0d", first_idx, exp_fidx); end
    total++; if (first_exp !== exp_exp)      begin bad++; $display("[TB] FAIL flags_on_exp got=%0h want=%0h", first_exp, exp_exp); end
  endtask

  task automatic test_stop_on_err;
    int cyc; bit to;
    fill_list(50);
    vr[10] = vr[10] ^ 16'h4000;
    vr[12] = vr[12] ^ 16'h0010;
    vr[30] = vr[30] ^ 16'h0100;
    model(1'b0, 1'b1);
    run_checker(1'b0, 1'b1, cyc, to);
    total++; if (to !== 1'b0)                begin bad++; $display("[TB] FAIL stop_timeout got=%0d want=0", to); end
    total++; if (vec_count !== CW'(exp_vec)) begin bad++; $display("[TB] FAIL stop_vec got=%0d want=%0d", vec_count, exp_vec); end
    total++; if (err_count !== CW'(exp_err)) begin bad++; $display("[TB] FAIL stop_err got=%0d want=%0d", err_count, exp_err); end
    total++; if (first_idx !== exp_fidx)     begin bad++; $display("[TB] FAIL stop_idx got=%0d want=%0d", first_idx, exp_fidx); end
    total++; if (done !== 1'b1)              begin bad++; $display("[TB] FAIL stop_done got=%0h want=1", done); end
  endtask

  task automatic test_wrap;
    int cyc; bit to;
    fill_list(DEPTH);
    model(1'b1, 1'b0);
    run_checker(1'b1, 1'b0, cyc, to);
    total++; if (to !== 1'b0)                begin bad++; $display("[TB] FAIL wrap_timeout got=%0d want=0", to); end
    total++; if (cyc !== exp_n + LAT + 2)    begin bad++; $display("[TB] FAIL wrap_latency got=%0d want=%0d", cyc, exp_n + LAT + 2); end
    total++; if (vec_count !== CW'(exp_vec)) begin bad++; $display("[TB] FAIL wrap_vec got=%0d want=%0d", vec_count, exp_vec); end
    total++; if (pass !== 1'b1)              begin bad++; $display("[TB] FAIL wrap_pass got=%0h want=1", pass); end
  endtask

  task automatic test_reset_midrun;
    int cyc; bit to;
    fill_list(60);
    vr[3] = vr[3] ^ 16'h0800;
    @(negedge clk);
    check_flags = 1'b0;
    stop_on_err = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midrun_busy got=%0h want=1", busy); end
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("[TB] FAIL midrun_rst_busy got=%0h want=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("[TB] FAIL midrun_rst_done got=%0h want=0", done); end
    total++; if (vec_count !== '0) begin bad++; $display("[TB] FAIL midrun_rst_vec got=%0d want=0", vec_count); end
    total++; if (first_idx !== '0) begin bad++; $display("[TB] FAIL midrun_rst_idx got=%0d want=0", first_idx); end
    @(negedge clk);
    reset_n = 1'b1;
    vr[3]  = vr[3] ^ 16'h0800;
    vr[41] = vr[41] ^ 16'h0004;
    model(1'b0, 1'b0);
    run_checker(1'b0, 1'b0, cyc, to);
    total++; if (to !== 1'b0)                begin bad++; $display("[TB] FAIL rerun_timeout got=%0d want=0", to); end
    total++; if (vec_count !== CW'(exp_vec)) begin bad++; $display("[TB] FAIL rerun_vec got=%0d want=%0d", vec_count, exp_vec); end
    total++; if (err_count !== CW'(exp_err)) begin bad++; $display("[TB] FAIL rerun_err got=%0d want=%0d", err_count, exp_err); end
    total++; if (first_idx !== exp_fidx)     begin bad++; $display("[TB] FAIL rerun_idx got=%0d want=%0d", first_idx, exp_fidx); end
  endtask

  task automatic test_back_to_back;
    int cyc; bit to;
    fill_list(25);
    vr[0] = vr[0] ^ 16'h8000;
    vf[24] = vf[24] ^ 4'h8;
    model(1'b1, 1'b0);
    run_checker(1'b1, 1'b0, cyc, to);
    total++; if (to !== 1'b0)                begin bad++; $display("[TB] FAIL b2b_timeout got=%0d want=0", to); end
    total++; if (vec_count !== CW'(exp_vec)) begin bad++; $display("[TB] FAIL b2b_vec got=%0d want=%0d", vec_count, exp_vec); end
    total++; if (err_count !== CW'(exp_err)) begin bad++; $display("[TB] FAIL b2b_err got=%0d want=%0d", err_count, exp_err); end
    total++; if (first_idx !== exp_fidx)     begin bad++; $display("[TB] FAIL b2b_idx got=%0d want=%0d", first_idx, exp_fidx); end
    total++; if (first_got !== exp_got)      begin bad++; $display("[TB] FAIL b2b_got got=%0h want=%0h", first_got, exp_got); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stream;
    test_mismatch;
    test_flags;
    test_stop_on_err;
    test_wrap;
    test_reset_midrun;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
